// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared state encoding and defaults for the pipeline stall/flush sequencer.
// Optional feature macro used by this slice: STALL_PERF_EN.
package pipeline_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_BUSY = 2'd1;

  localparam int MDU_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MDU_BUSY = ST_MDU_BUSY
  } stall_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline-control outputs of the stall sequencer.
// With STALL_PERF_EN defined the interface also carries the perf counters.
interface pipeline_stall_ctrl_if;

  logic       hazard_hz;
  logic       branch_taken;
  logic       mdu_start;
  logic       mdu_done;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       memwb_bubble;
  logic       mdu_timeout;
  logic [1:0] stall_state;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  modport master (
    output hazard_hz, branch_taken, mdu_start, mdu_done, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en,
    input  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
`ifdef STALL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  mdu_timeout, stall_state
  );

  modport slave (
    input  hazard_hz, branch_taken, mdu_start, mdu_done, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en,
    output ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
`ifdef STALL_PERF_EN
    output stall_cycles, flush_count,
`endif
    output mdu_timeout, stall_state
  );

endinterface

// File: rtl/pipeline_stall_ctrl_watchdog.sv
// MDU busy watchdog: counts unfrozen busy cycles and raises a sticky flag
// when the op exceeds TIMEOUT cycles without completing.
module mdu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic cnt_en,
  input  logic done,
  output logic expired,
  output logic timeout_flag
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         flag_q, flag_d;

  // The compare alone; the caller only acts on it in a counting cycle.
  assign expired      = (cnt_q == LIMIT) && !done;
  assign timeout_flag = flag_q;

  // Next counter value and sticky flag.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear) begin
      cnt_d = {W{1'b0}};
    end else if (cnt_en && !done) begin
      cnt_d = cnt_q + W'(1);
      if (expired) begin
        flag_d = 1'b1;
      end else begin
        flag_d = flag_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= {W{1'b0}};
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: arbitrates reset, memory freeze, MDU stall,
// branch flush and load-use stall. STALL_PERF_EN adds perf counters.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.slave  bus
);

  stall_state_e state_q, state_d;
  logic         done_pending_q, done_pending_d;

  logic freeze_s, done_eff_s, mdu_stall_s;
  logic wd_clear_s, wd_cnt_en_s, wd_expired_s, wd_flag_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s;
  logic ifid_flush_s, idex_bubble_s, exmem_bubble_s, memwb_bubble_s;

  assign freeze_s    = bus.dmem_req && !bus.dmem_ready;
  assign done_eff_s  = bus.mdu_done || done_pending_q;
  assign mdu_stall_s = ((state_q == S_MDU_BUSY) && !done_eff_s) ||
                       ((state_q == S_RUN) && bus.mdu_start && !bus.mdu_done);

  // Mealy control outputs and next state, in hazard-priority order.
  always_comb begin
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    idex_en_s      = 1'b1;
    exmem_en_s     = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    exmem_bubble_s = 1'b0;
    memwb_bubble_s = 1'b0;
    state_d        = state_q;
    done_pending_d = done_pending_q;
    wd_clear_s     = 1'b0;
    wd_cnt_en_s    = 1'b0;
    if (reset) begin
      pc_en_s        = 1'b0;
      ifid_en_s      = 1'b0;
      idex_en_s      = 1'b0;
      exmem_en_s     = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_bubble_s  = 1'b1;
      exmem_bubble_s = 1'b1;
      memwb_bubble_s = 1'b1;
      state_d        = S_RUN;
      done_pending_d = 1'b0;
    end else if (freeze_s) begin
      pc_en_s        = 1'b0;
      ifid_en_s      = 1'b0;
      idex_en_s      = 1'b0;
      exmem_en_s     = 1'b0;
      memwb_bubble_s = 1'b1;
      // A completion seen while frozen must survive until the release cycle.
      if ((state_q == S_MDU_BUSY) && bus.mdu_done) begin
        done_pending_d = 1'b1;
      end else begin
        done_pending_d = done_pending_q;
      end
    end else if (mdu_stall_s) begin
      pc_en_s        = 1'b0;
      ifid_en_s      = 1'b0;
      idex_en_s      = 1'b0;
      exmem_bubble_s = 1'b1;
      if (state_q == S_RUN) begin
        state_d        = S_MDU_BUSY;
        wd_clear_s     = 1'b1;
        done_pending_d = 1'b0;
      end else begin
        wd_cnt_en_s = 1'b1;
        if (wd_expired_s) begin
          state_d = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
    end else if (state_q == S_MDU_BUSY) begin
      state_d        = S_RUN;
      done_pending_d = 1'b0;
    end else if (bus.branch_taken) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (bus.hazard_hz) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_bubble_s = 1'b1;
    end else begin
      state_d = state_q;
    end
    // An unencoded state recovers to RUN.
    case (state_q)
      S_RUN, S_MDU_BUSY: state_d = state_d;
      default:           state_d = S_RUN;
    endcase
  end

  // Stall FSM state and pending-done latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RUN;
      done_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_pending_q <= done_pending_d;
    end
  end

  mdu_watchdog #(
    .TIMEOUT (MDU_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .clear        (wd_clear_s),
    .cnt_en       (wd_cnt_en_s),
    .done         (done_eff_s),
    .expired      (wd_expired_s),
    .timeout_flag (wd_flag_s)
  );

  assign bus.pc_en        = pc_en_s;
  assign bus.ifid_en      = ifid_en_s;
  assign bus.idex_en      = idex_en_s;
  assign bus.exmem_en     = exmem_en_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.idex_bubble  = idex_bubble_s;
  assign bus.exmem_bubble = exmem_bubble_s;
  assign bus.memwb_bubble = memwb_bubble_s;
  assign bus.mdu_timeout  = wd_flag_s;
  assign bus.stall_state  = state_q;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Perf counter increments; both wrap naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!reset && !pc_en_s) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (!reset && ifid_flush_s) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed cycles push expected
// output vectors; a negedge monitor pops and compares them.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if bus_a ();
  pipeline_stall_ctrl_if bus_b ();

  pipeline_stall_ctrl #(.MDU_TIMEOUT(64)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  pipeline_stall_ctrl #(.MDU_TIMEOUT(4))  dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  // input vector {reset, hazard, branch, start, done, dmem_req, dmem_ready}
  localparam logic [6:0] I_IDLE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_HZ   = 7'b0100000;
  localparam logic [6:0] I_BR   = 7'b0010000;
  localparam logic [6:0] I_ST   = 7'b0001000;
  localparam logic [6:0] I_DN   = 7'b0000100;
  localparam logic [6:0] I_FRZ  = 7'b0000010;

  // output vector {pc,ifid,idex,exmem, flush,idex_b,exmem_b,memwb_b, timeout, state}
  localparam logic [10:0] E_DEF   = 11'b1111_0000_0_00;
  localparam logic [10:0] E_HZ    = 11'b0011_0100_0_00;
  localparam logic [10:0] E_BR    = 11'b1111_1100_0_00;
  localparam logic [10:0] E_STR   = 11'b0001_0010_0_00;
  localparam logic [10:0] E_STB   = 11'b0001_0010_0_01;
  localparam logic [10:0] E_FRB   = 11'b0000_0001_0_01;
  localparam logic [10:0] E_FRR   = 11'b0000_0001_0_00;
  localparam logic [10:0] E_RLB   = 11'b1111_0000_0_01;
  localparam logic [10:0] E_RST   = 11'b0000_1111_0_00;
  localparam logic [10:0] E_RSTB  = 11'b0000_1111_0_01;
  localparam logic [10:0] E_TO    = 11'b1111_0000_1_00;
  localparam logic [10:0] E_RSTTO = 11'b0000_1111_1_00;

  typedef struct {
    string       name;
    bit          which;
    logic [10:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   pushed       = 0;

  function automatic logic [10:0] outs_of(bit which);
    if (which)
      return {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
              bus_b.ifid_flush, bus_b.idex_bubble, bus_b.exmem_bubble, bus_b.memwb_bubble,
              bus_b.mdu_timeout, bus_b.stall_state};
    else
      return {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
              bus_a.ifid_flush, bus_a.idex_bubble, bus_a.exmem_bubble, bus_a.memwb_bubble,
              bus_a.mdu_timeout, bus_a.stall_state};
  endfunction

  task automatic drive(bit which, logic [6:0] v);
    logic [6:0] va, vb;
    va = which ? I_IDLE : v;
    vb = which ? v : I_IDLE;
    {reset_a, bus_a.hazard_hz, bus_a.branch_taken, bus_a.mdu_start,
     bus_a.mdu_done, bus_a.dmem_req, bus_a.dmem_ready} = va;
    {reset_b, bus_b.hazard_hz, bus_b.branch_taken, bus_b.mdu_start,
     bus_b.mdu_done, bus_b.dmem_req, bus_b.dmem_ready} = vb;
  endtask

  task automatic push(string name, bit which, logic [10:0] exp);
    exp_t e;
    e.name  = name;
    e.which = which;
    e.exp   = exp;
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic step(string name, bit which, logic [6:0] v, logic [10:0] exp);
    @(posedge clk);
    #1;
    drive(which, v);
    push(name, which, exp);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = outs_of(e.which);
        tests_run++;
        if (act !== e.exp) begin
          tests_failed++;
          $display("FAIL %s dut=%0d got=%b expected=%b", e.name, e.which, act, e.exp);
        end
      end
    end
  end

  initial begin
    drive(1'b0, I_IDLE);
    reset_a = 1'b1;
    reset_b = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    push("reset_a", 1'b0, E_RST);
    push("reset_b", 1'b1, E_RST);

    // Load-use and branch arbitration.
    step("idle",          1'b0, I_IDLE,      E_DEF);
    step("hazard",        1'b0, I_HZ,        E_HZ);
    step("hazard_1cyc",   1'b0, I_IDLE,      E_DEF);
    step("hazard_branch", 1'b0, I_HZ | I_BR, E_BR);
    step("branch",        1'b0, I_BR,        E_BR);

    // MDU op with done five cycles after start.
    step("mdu_start",     1'b0, I_ST, E_STR);
    for (int i = 0; i < 4; i++) step("mdu_busy", 1'b0, I_ST, E_STB);
    step("mdu_done",      1'b0, I_ST | I_DN, E_RLB);
    step("mdu_after",     1'b0, I_IDLE, E_DEF);

    step("mdu_single",    1'b0, I_ST | I_DN, E_DEF);
    step("branch_mdu",    1'b0, I_BR | I_ST, E_STR);
    step("branch_mdu_dn", 1'b0, I_ST | I_DN, E_RLB);
    step("branch_mdu_af", 1'b0, I_IDLE, E_DEF);

    // Freeze during MDU_BUSY, done latched in the middle freeze cycle.
    step("frz_start",     1'b0, I_ST,                E_STR);
    step("frz_busy",      1'b0, I_ST,                E_STB);
    step("frz_c1",        1'b0, I_ST | I_FRZ,        E_FRB);
    step("frz_c2_done",   1'b0, I_ST | I_FRZ | I_DN, E_FRB);
    step("frz_c3",        1'b0, I_ST | I_FRZ,        E_FRB);
    step("frz_release",   1'b0, I_ST,                E_RLB);
    step("frz_after",     1'b0, I_IDLE,              E_DEF);
    step("frz_run_hz",    1'b0, I_FRZ | I_HZ,        E_FRR);

    // Reset in the middle of an MDU stall.
    step("rst_start",     1'b0, I_ST,         E_STR);
    step("rst_busy",      1'b0, I_ST,         E_STB);
    step("rst_mid",       1'b0, I_RST | I_ST, E_RSTB);
    step("rst_after",     1'b0, I_IDLE,       E_DEF);
`ifdef STALL_PERF_EN
    @(negedge clk);
    #1;
    tests_run++;
    if (bus_a.stall_cycles !== 32'd0 || bus_a.flush_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_reset got=%0d/%0d expected=0/0", bus_a.stall_cycles, bus_a.flush_count);
    end
`endif

    // Watchdog on the MDU_TIMEOUT=4 instance.
    step("wd_start",      1'b1, I_ST, E_STR);
    for (int i = 0; i < 4; i++) step("wd_busy", 1'b1, I_IDLE, E_STB);
    step("wd_fired",      1'b1, I_IDLE, E_TO);
    step("wd_sticky",     1'b1, I_IDLE, E_TO);
    step("wd_reset",      1'b1, I_RST,  E_RSTTO);
    step("wd_cleared",    1'b1, I_IDLE, E_DEF);

    @(posedge clk);
    #1;
    drive(1'b0, I_IDLE);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (sb_q.size() != 0 || tests_run - 1 < pushed) begin
      tests_failed++;
      $display("FAIL drain got=%0d pending expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It sits downstream of the combinational load-use hazard detector and consumes its `hazard_hz`, plus the multi-cycle MDU, data-memory and branch-resolution conditions. It then drives every pipeline-register enable, bubble and flush control. It owns the only multi-cycle stall state in the core, so it is the single point that arbitrates between the different hazard sources.

## Interface
- `MDU_TIMEOUT`, default 64: maximum MDU busy cycles, excluding frozen cycles, before a forced abort.
- `clk` in 1: the single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `hazard_hz` in 1: load-use hazard from the hazard detector.
- `branch_taken` in 1: a branch or jump resolved taken in EX.
- `mdu_start` in 1: a multi-cycle mul/div op is in EX.
- `mdu_done` in 1: MDU result valid this cycle.
- `dmem_req` in 1: a MEM-stage access is pending.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en` out 1 each: pipeline register write enables.
- `ifid_flush`, `idex_bubble`, `exmem_bubble`, `memwb_bubble` out 1 each: insert a NOP into the named register.
- `mdu_timeout` out 1: sticky error flag, set when the MDU watchdog fires.
- `stall_state` out 2: current FSM state.

## Operation
- FSM states: `RUN`, `MDU_BUSY`. Outputs are Mealy: a function of the current state and the current-cycle inputs.
- Default (`RUN`, no condition active): all `*_en` signals are 1; all flush and bubble signals are 0.
- Priority per cycle, highest first:
  1. `reset`: `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0; `ifid_flush`, `idex_bubble`, `exmem_bubble` and `memwb_bubble` are 1. The state register loads `RUN`; `done_pending`, the watchdog counter and `mdu_timeout` clear to 0.
  2. Memory freeze (`dmem_req & ~dmem_ready`): all four enables are 0, `memwb_bubble`=1, all other bubbles and flushes are 0. The FSM holds and the watchdog holds.
     - If `mdu_done` rises during a freeze, it is latched in `done_pending`. It is never lost.
  3. MDU stall: applies in `MDU_BUSY` with no `mdu_done` and no `done_pending`, or in `RUN` with `mdu_start & ~mdu_done`.
     - Outputs: `pc_en`=`ifid_en`=`idex_en`=0, `exmem_bubble`=1.
     - In `RUN` this case transitions to `MDU_BUSY`.
  4. MDU release: `MDU_BUSY` with (`mdu_done` or `done_pending`) and no freeze. Outputs are the default; next state is `RUN`; `done_pending` clears.
  5. `branch_taken`: `pc_en`=1, `ifid_flush`=1, `idex_bubble`=1. `hazard_hz` is ignored in this cycle.
  6. `hazard_hz`: `pc_en`=0, `ifid_en`=0, `idex_bubble`=1. This is a one-cycle stall with no state change.
- `mdu_start` together with `mdu_done` in `RUN`: no stall (single-cycle op).
- `branch_taken` together with `mdu_start`: the MDU stall wins. The branch is re-presented because EX is held.
- Watchdog:
  - The counter is `$clog2(MDU_TIMEOUT+1)` bits wide and clears on entry to `MDU_BUSY`.
  - It increments on each non-frozen `MDU_BUSY` cycle without done.
  - When the count equals `MDU_TIMEOUT-1` and done is absent, `mdu_timeout` sets (it stays set until reset) and the next state is `RUN`. Outputs in that cycle are still stalled.

## Timing
- Every stall, bubble and flush takes effect in the same cycle as its cause (zero latency).
- A load-use hazard costs exactly 1 cycle.
- A taken branch costs 2 squashed slots, applied in the single resolving cycle.
- An MDU op with done arriving N cycles after start stalls for N cycles; the pipeline resumes in the done cycle.
- A freeze extends any stall by exactly the number of frozen cycles.
- A `reset` asserted mid-stall takes effect the same cycle; the next cycle is clean `RUN`.

## Configuration
- `STALL_PERF_EN`: adds the output `stall_cycles[31:0]` and the output `flush_count[31:0]`. Both clear on reset and wrap at 2^32.
  - `stall_cycles` increments on any cycle with `pc_en`=0 outside reset.
  - `flush_count` increments on each `ifid_flush` outside reset.
- Without the macro, these ports and their counters do not exist. Pipeline behaviour is identical either way.

## Structure
- `pipeline_pkg` holds:
  - the state encoding constants `ST_RUN`=2'd0 and `ST_MDU_BUSY`=2'd1;
  - the default `MDU_TIMEOUT`.
- Sub-module `mdu_watchdog` contains the counter, the compare and the sticky `mdu_timeout` flag. Its inputs are clear, count enable and done; its outputs are expired and the sticky flag.

## Test plan
- `hazard_hz`=1 for one cycle in `RUN` -> `pc_en`=0, `ifid_en`=0, `idex_bubble`=1 in that cycle only; `stall_state` stays 0.
- `hazard_hz` and `branch_taken` both 1 -> `pc_en`=1, `ifid_flush`=1, `idex_bubble`=1.
- `mdu_start`, then `mdu_done` 5 cycles later -> 5 cycles with `pc_en`=0 and `exmem_bubble`=1. In the done cycle the outputs are at default and the next `stall_state` is 0.
- In `MDU_BUSY`, `dmem_req`=1 with `dmem_ready`=0 for 3 cycles, and `mdu_done` pulses in freeze cycle 2 -> all enables 0 for the 3 cycles, then release on the first unfrozen cycle.
- `MDU_TIMEOUT`=4 and `mdu_done` never asserts -> `mdu_timeout`=1 after 4 busy cycles; state `RUN` the next cycle; the flag persists until `reset`.
- `reset` during `MDU_BUSY` -> the same cycle shows all enables 0 and all bubbles 1; the next cycle shows `RUN` defaults and `mdu_timeout`=0. With `STALL_PERF_EN` defined, both counters are 0.
